// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses Instruction_Mem and fills the
// IF/ID register, with stall, redirect/flush, sticky fault and fetch counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 128,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Target,
  input  logic [31:0] Inst,
  output logic [31:0] Dir,
  output logic [31:0] PC_ID,
  output logic [31:0] PCplus4_ID,
  output logic [31:0] Inst_ID,
  output logic        Valid_ID,
  output logic        Fault,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_range;

  assign Dir      = {2'b00, pc[31:2]};
  assign pc_plus4 = pc + 32'd4;
  assign in_range = (Dir < MEM_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      PC_ID      <= '0;
      PCplus4_ID <= 32'd4;
      Inst_ID    <= NOP;
      Valid_ID   <= 1'b0;
      Fault      <= 1'b0;
      FetchCount <= '0;
    end else if (Redirect) begin
      pc       <= Target & ~32'h3;
      Inst_ID  <= NOP;
      Valid_ID <= 1'b0;
      if (Target[1:0] != 2'b00) Fault <= 1'b1;
    end else if (!Stall) begin
      PC_ID      <= pc;
      PCplus4_ID <= pc_plus4;
      if (in_range) begin
        Inst_ID    <= Inst;
        Valid_ID   <= 1'b1;
        FetchCount <= FetchCount + 32'd1;
        pc         <= pc_plus4;
      end else begin
        // Out-of-range fetch parks on the faulting PC until redirect or reset.
        Inst_ID  <= NOP;
        Valid_ID <= 1'b0;
        Fault    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Target = '0;
  logic [31:0] Inst;
  logic [31:0] Dir, PC_ID, PCplus4_ID, Inst_ID, FetchCount;
  logic        Valid_ID, Fault;

  logic [31:0] mem [128];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_pc, m_pcid, m_p4, m_inst, m_cnt;
  logic        m_valid, m_fault;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(128),
    .NOP      (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .Target    (Target),
    .Inst      (Inst),
    .Dir       (Dir),
    .PC_ID     (PC_ID),
    .PCplus4_ID(PCplus4_ID),
    .Inst_ID   (Inst_ID),
    .Valid_ID  (Valid_ID),
    .Fault     (Fault),
    .FetchCount(FetchCount)
  );

  always #5 clk = ~clk;

  always_comb begin
    Inst = 32'hDEAD_BEEF;
    if (Dir < 32'd128) Inst = mem[Dir[6:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("dir",   Dir,        m_pc / 4);
    check("pc_id", PC_ID,      m_pcid);
    check("p4_id", PCplus4_ID, m_p4);
    check("inst",  Inst_ID,    m_inst);
    check("valid", {31'd0, Valid_ID}, {31'd0, m_valid});
    check("fault", {31'd0, Fault},    {31'd0, m_fault});
    check("count", FetchCount, m_cnt);
  endtask

  // One clock edge: drive inputs away from the edge, advance the model, compare after.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
    int unsigned widx;
    @(negedge clk);
    rst = r; Stall = s; Redirect = rd; Target = t;
    widx = m_pc / 4;
    if (r) begin
      m_pc = 32'h0; m_pcid = 32'h0; m_p4 = 32'd4; m_inst = NOP;
      m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc = t - (t % 4);
      m_inst = NOP; m_valid = 1'b0;
      if (t % 4 != 0) m_fault = 1'b1;
    end else if (!s) begin
      m_pcid = m_pc;
      m_p4 = m_pc + 4;
      if (widx < 128) begin
        m_inst = mem[widx]; m_valid = 1'b1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
      end else begin
        m_inst = NOP; m_valid = 1'b0; m_fault = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    m_pc = '0; m_pcid = '0; m_p4 = '0; m_inst = '0; m_cnt = '0; m_valid = 0; m_fault = 0;

    // Reset state and free-running fetch of words 0..3.
    step(1, 0, 0, 0);
    check("rst_valid", {31'd0, Valid_ID}, 32'd0);
    check("rst_inst",  Inst_ID, NOP);
    check("rst_p4",    PCplus4_ID, 32'd4);
    step(0, 0, 0, 0);
    check("tp1_first_inst", Inst_ID, mem[0]);
    check("tp1_first_pc",   PC_ID, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("tp1_inst_d", Inst_ID, mem[3]);
    check("tp1_count",  FetchCount, 32'd4);
    check("tp1_fault",  {31'd0, Fault}, 32'd0);

    // Stall held at Dir=2, then release.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("tp2_dir_held", Dir, 32'd2);
    check("tp2_cnt_held", FetchCount, 32'd2);
    step(0, 0, 0, 0);
    check("tp2_release_pc", PC_ID, 32'h8);
    check("tp2_release_inst", Inst_ID, mem[2]);

    // Redirect wins over simultaneous stall.
    step(0, 1, 1, 32'h40);
    check("tp3_dir", Dir, 32'd16);
    check("tp3_valid", {31'd0, Valid_ID}, 32'd0);
    step(0, 0, 0, 0);
    check("tp3_pc_id", PC_ID, 32'h40);
    check("tp3_p4", PCplus4_ID, 32'h44);
    check("tp3_inst", Inst_ID, mem[16]);

    // Misaligned redirect: sticky fault.
    step(0, 0, 1, 32'h22);
    check("tp4_dir", Dir, 32'd8);
    check("tp4_fault", {31'd0, Fault}, 32'd1);
    for (int i = 0; i < 10; i++) step(0, i % 3 == 0, 0, 0);
    check("tp4_sticky", {31'd0, Fault}, 32'd1);

    // Last word then out-of-range.
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h1FC);
    step(0, 0, 0, 0);
    check("tp5_last_inst", Inst_ID, mem[127]);
    check("tp5_last_valid", {31'd0, Valid_ID}, 32'd1);
    step(0, 0, 0, 0);
    check("tp5_oor_valid", {31'd0, Valid_ID}, 32'd0);
    check("tp5_oor_fault", {31'd0, Fault}, 32'd1);
    check("tp5_oor_dir", Dir, 32'd128);
    check("tp5_oor_count", FetchCount, 32'd1);
    step(0, 0, 0, 0);
    check("tp5_pc_held", Dir, 32'd128);

    // Redirect to top of address space: PCplus4 wraps.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_pc_id", PC_ID, 32'hFFFF_FFFC);
    check("wrap_p4", PCplus4_ID, 32'h0);

    // Reset mid-run with counters and fault set and Stall high.
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h3);
    check("tp6_pre_count", FetchCount, 32'd7);
    step(1, 1, 0, 0);
    check("tp6_dir", Dir, 32'd0);
    check("tp6_count", FetchCount, 32'd0);
    check("tp6_fault", {31'd0, Fault}, 32'd0);
    check("tp6_inst", Inst_ID, NOP);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, s, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) < 3);
      s  = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 12);
      t  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h23F));
      step(r, s, rd, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
